// File: rtl/mem_port_client_if.sv
// Arbiter-lane bundle for one memory port client: request/address/data toward the
// shared arbiter, grant and RAM read data back from it.
interface mem_port_client_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          rden;
    logic          wren;
    logic [AW-1:0] addr_out;
    logic [DW-1:0] din_out;
    logic          acq;
    logic [DW-1:0] dq;

    modport master (
        output rden,
        output wren,
        output addr_out,
        output din_out,
        input  acq,
        input  dq
    );

    modport slave (
        input  rden,
        input  wren,
        input  addr_out,
        input  din_out,
        output acq,
        output dq
    );
endinterface

// File: rtl/mem_port_client.sv
// Per-core memory request front-end: latches one load/store, holds it on the arbiter
// lane until granted, captures read data after RD_LAT cycles and pulses done.
module mem_port_client #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [AW-1:0]     mem_addr,
    input  logic [DW-1:0]     mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [DW-1:0]     rdata,
    output logic              timeout,
    mem_port_client_if.master arb
);

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam int LCW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state, state_n;
    logic            rden_q, rden_n;
    logic            wren_q, wren_n;
    logic [AW-1:0]   addr_q, addr_n;
    logic [DW-1:0]   din_q, din_n;
    logic [DW-1:0]   rdata_n;
    logic            done_n;
    logic            busy_n;
    logic            timeout_n;
    logic [WCW-1:0]  wait_cnt, wait_n;
    logic [LCW-1:0]  lat_cnt, lat_n;

    assign arb.rden     = rden_q;
    assign arb.wren     = wren_q;
    assign arb.addr_out = addr_q;
    assign arb.din_out  = din_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rden_q   <= 1'b0;
            wren_q   <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            rdata    <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            wait_cnt <= '0;
            lat_cnt  <= '0;
        end else begin
            state    <= state_n;
            rden_q   <= rden_n;
            wren_q   <= wren_n;
            addr_q   <= addr_n;
            din_q    <= din_n;
            rdata    <= rdata_n;
            done     <= done_n;
            busy     <= busy_n;
            timeout  <= timeout_n;
            wait_cnt <= wait_n;
            lat_cnt  <= lat_n;
        end
    end

    // Every output is computed here one cycle ahead and registered above, so done
    // is high exactly during the DONE state and busy mirrors the state register.
    always_comb begin
        state_n   = state;
        rden_n    = rden_q;
        wren_n    = wren_q;
        addr_n    = addr_q;
        din_n     = din_q;
        rdata_n   = rdata;
        done_n    = 1'b0;
        timeout_n = timeout;
        wait_n    = wait_cnt;
        lat_n     = lat_cnt;

        case (state)
            IDLE: begin
                if (mem_wr || mem_rd) begin
                    addr_n  = mem_addr;
                    din_n   = mem_wdata;
                    wren_n  = mem_wr;
                    rden_n  = ~mem_wr;
                    state_n = REQ;
                end
            end

            REQ: begin
                // Starvation is only reported; the request keeps waiting for a grant.
                if (wait_cnt != WCW'(TIMEOUT)) begin
                    wait_n = wait_cnt + WCW'(1);
                end
                if (wait_n == WCW'(TIMEOUT)) begin
                    timeout_n = 1'b1;
                end
                if (arb.acq) begin
                    if (wren_q) begin
                        wren_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        lat_n   = LCW'(1);
                        state_n = HOLD;
                    end
                end
            end

            HOLD: begin
                if (!arb.acq) begin
                    lat_n   = '0;
                    state_n = REQ;
                end else if (lat_cnt == LCW'(RD_LAT)) begin
                    rdata_n = arb.dq;
                    rden_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    lat_n = lat_cnt + LCW'(1);
                end
            end

            DONE: begin
                wait_n  = '0;
                lat_n   = '0;
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_mem_port_client.sv
// Self-checking bench for mem_port_client: a small arbiter/RAM model, directed
// accesses and a scoreboard that checks rdata on every done pulse.
module tb_mem_port_client;

    logic       clk;
    logic       rst;
    logic       memRd, memWr;
    logic [7:0] memAddr, memWdata;
    logic       busy, done, timeout;
    logic [7:0] rdata;

    logic       s2Rd, s2Wr;
    logic [7:0] s2Addr, s2Wdata;
    logic       busy2, done2, timeout2;
    logic [7:0] rdata2;

    logic [7:0] dqMask;
    logic [7:0] ram [256];
    logic [7:0] sb [$];

    int checks;
    int errors;

    mem_port_client_if #(.AW(8), .DW(8)) arbIf ();
    mem_port_client_if #(.AW(8), .DW(8)) arb2If ();

    mem_port_client #(.AW(8), .DW(8), .RD_LAT(1), .TIMEOUT(255)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_rd    (memRd),
        .mem_wr    (memWr),
        .mem_addr  (memAddr),
        .mem_wdata (memWdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .timeout   (timeout),
        .arb       (arbIf.master)
    );

    mem_port_client #(.AW(8), .DW(8), .RD_LAT(1), .TIMEOUT(4)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .mem_rd    (s2Rd),
        .mem_wr    (s2Wr),
        .mem_addr  (s2Addr),
        .mem_wdata (s2Wdata),
        .busy      (busy2),
        .done      (done2),
        .rdata     (rdata2),
        .timeout   (timeout2),
        .arb       (arb2If.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM behind the arbiter: writes commit on granted edges, read data is
    // registered (optionally corrupted by dqMask to expose early captures).
    always @(posedge clk) begin
        if (arbIf.acq && arbIf.wren) begin
            ram[arbIf.addr_out] <= arbIf.din_out;
        end
        arbIf.dq <= ram[arbIf.addr_out] ^ dqMask;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Present a request for exactly one sampling edge, then withdraw it.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        memRd    = rd;
        memWr    = wr;
        memAddr  = a;
        memWdata = d;
        tick();
        memRd    = 1'b0;
        memWr    = 1'b0;
        memAddr  = 8'h00;
        memWdata = 8'h00;
    endtask

    task automatic waitDone(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) checkOutput("done_wait", {31'd0, done}, 32'd1);
    endtask

    // Scoreboard consumer: every done pulse must match one queued expectation.
    task automatic monitor();
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done actual=done required=no_done");
                end else begin
                    exp = sb.pop_front();
                    checkOutput("done_rdata", {24'd0, rdata}, {24'd0, exp});
                end
            end
        end
    endtask

    // Full access: request, lowCycles of withheld grant (outputs must stay put),
    // then grant until done; checks latency and the idle state afterwards.
    task automatic doAccess(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                            input int lowCycles, input logic [7:0] expRdata);
        int n;
        int m;
        int expLat;
        expLat = wr ? (2 + lowCycles) : (3 + lowCycles);
        sb.push_back(expRdata);
        applyStimulus(rd, wr, a, d);
        n = 0;
        for (int i = 0; i <= lowCycles; i++) begin
            checkOutput("req_rden", {31'd0, arbIf.rden}, {31'd0, rd & ~wr});
            checkOutput("req_wren", {31'd0, arbIf.wren}, {31'd0, wr});
            checkOutput("req_addr", {24'd0, arbIf.addr_out}, {24'd0, a});
            checkOutput("req_din", {24'd0, arbIf.din_out}, {24'd0, d});
            checkOutput("req_busy", {31'd0, busy}, 32'd1);
            checkOutput("req_done", {31'd0, done}, 32'd0);
            tick();
            n++;
        end
        arbIf.acq = 1'b1;
        waitDone(m);
        checkOutput("latency", n + m, expLat);
        arbIf.acq = 1'b0;
        tick();
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("idle_done", {31'd0, done}, 32'd0);
        checkOutput("idle_rden", {31'd0, arbIf.rden}, 32'd0);
        checkOutput("idle_wren", {31'd0, arbIf.wren}, 32'd0);
        checkOutput("idle_addr_kept", {24'd0, arbIf.addr_out}, {24'd0, a});
    endtask

    initial begin
        int n;
        checks   = 0;
        errors   = 0;
        dqMask   = 8'h00;
        rst      = 1'b1;
        memRd    = 1'b0;
        memWr    = 1'b0;
        memAddr  = 8'h00;
        memWdata = 8'h00;
        s2Rd     = 1'b0;
        s2Wr     = 1'b0;
        s2Addr   = 8'h00;
        s2Wdata  = 8'h00;
        arbIf.acq  = 1'b0;
        arb2If.acq = 1'b0;
        arb2If.dq  = 8'h00;
        fork
            monitor();
        join_none
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_rdata", {24'd0, rdata}, 32'd0);
        checkOutput("rst_timeout", {31'd0, timeout}, 32'd0);
        checkOutput("rst_rden", {31'd0, arbIf.rden}, 32'd0);
        checkOutput("rst_wren", {31'd0, arbIf.wren}, 32'd0);
        checkOutput("rst_addr", {24'd0, arbIf.addr_out}, 32'd0);
        checkOutput("rst_din", {24'd0, arbIf.din_out}, 32'd0);

        // Write then read back, no contention
        doAccess(1'b0, 1'b1, 8'h3A, 8'h5C, 0, 8'h00);
        checkOutput("ram_3a", {24'd0, ram[8'h3A]}, 32'h5C);
        doAccess(1'b1, 1'b0, 8'h3A, 8'h00, 0, 8'h5C);
        checkOutput("rdata_hold", {24'd0, rdata}, 32'h5C);

        // Contention: grant withheld for 10 cycles
        doAccess(1'b0, 1'b1, 8'h10, 8'hA7, 10, 8'h5C);
        checkOutput("ram_10", {24'd0, ram[8'h10]}, 32'hA7);
        doAccess(1'b1, 1'b0, 8'h10, 8'h00, 10, 8'hA7);
        checkOutput("contention_timeout", {31'd0, timeout}, 32'd0);

        // Pre-emption: first grant lasts one cycle with corrupted dq, second is clean
        doAccess(1'b0, 1'b1, 8'h40, 8'h11, 0, 8'hA7);
        dqMask = 8'hFF;
        sb.push_back(8'h11);
        applyStimulus(1'b1, 1'b0, 8'h40, 8'h00);
        tick();
        arbIf.acq = 1'b1;
        tick();
        checkOutput("pre_hold_rden", {31'd0, arbIf.rden}, 32'd1);
        checkOutput("pre_hold_done", {31'd0, done}, 32'd0);
        arbIf.acq = 1'b0;
        tick();
        checkOutput("pre_req_rden", {31'd0, arbIf.rden}, 32'd1);
        checkOutput("pre_req_busy", {31'd0, busy}, 32'd1);
        checkOutput("pre_req_done", {31'd0, done}, 32'd0);
        dqMask = 8'h00;
        tick();
        tick();
        arbIf.acq = 1'b1;
        waitDone(n);
        checkOutput("pre_latency", n, 2);
        arbIf.acq = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checkOutput("pre_one_done", sb.size(), 0);
        checkOutput("pre_rdata", {24'd0, rdata}, 32'h11);

        // Priority: simultaneous rd/wr is a write; a rd pulse during REQ is ignored
        sb.push_back(8'h11);
        applyStimulus(1'b1, 1'b1, 8'h55, 8'h99);
        checkOutput("prio_wren", {31'd0, arbIf.wren}, 32'd1);
        checkOutput("prio_rden", {31'd0, arbIf.rden}, 32'd0);
        memRd   = 1'b1;
        memAddr = 8'h66;
        tick();
        memRd   = 1'b0;
        memAddr = 8'h00;
        checkOutput("ignore_rden", {31'd0, arbIf.rden}, 32'd0);
        checkOutput("ignore_addr", {24'd0, arbIf.addr_out}, 32'h55);
        arbIf.acq = 1'b1;
        waitDone(n);
        checkOutput("prio_latency", n, 1);
        arbIf.acq = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checkOutput("prio_one_done", sb.size(), 0);
        checkOutput("prio_busy", {31'd0, busy}, 32'd0);
        checkOutput("ram_55", {24'd0, ram[8'h55]}, 32'h99);

        // Starvation on the TIMEOUT=4 instance, grant never given
        s2Rd   = 1'b1;
        s2Addr = 8'h77;
        tick();
        s2Rd   = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checkOutput("starve_timeout", {31'd0, timeout2}, (k >= 4) ? 32'd1 : 32'd0);
            checkOutput("starve_busy", {31'd0, busy2}, 32'd1);
        end
        checkOutput("starve_rden", {31'd0, arb2If.rden}, 32'd1);
        checkOutput("starve_done", {31'd0, done2}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst2_timeout", {31'd0, timeout2}, 32'd0);
        checkOutput("rst2_busy", {31'd0, busy2}, 32'd0);
        checkOutput("rst2_rden", {31'd0, arb2If.rden}, 32'd0);
        checkOutput("rst2_addr", {24'd0, arb2If.addr_out}, 32'd0);
        checkOutput("rst2_rdata", {24'd0, rdata2}, 32'd0);
        checkOutput("rst1_rdata", {24'd0, rdata}, 32'd0);
        tick();
        checkOutput("rst2_idle_busy", {31'd0, busy2}, 32'd0);

        checkOutput("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
